// File: rtl/buzzer_tone_gen.sv
// buzzer_tone_gen: 50 % duty square-wave tone generator for the passive buzzer.
// A note code selects a half-period from an elaboration-time table. Pitch
// changes and note-offs land only on half-period boundaries, except when the
// wave is already low, where a stop may take effect at once.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous active-high reset
//   key_on  - request to sound the note on key
//   key     - note code: 1-7 = C4..B4, 8-14 = C5..B5, 0/15 = rest
//   speaker - registered square wave to the buzzer
//   playing - registered, high while a tone is generated
//   cur_key - registered note code currently sounding, 0 when idle
module buzzer_tone_gen #(
   parameter int unsigned CLK_HZ = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_on,
   input  logic [3:0] key,
   output logic       speaker,
   output logic       playing,
   output logic [3:0] cur_key
);

   localparam int unsigned CNT_W = 20;
   localparam int unsigned KEY_W = 4;
   localparam int unsigned N_KEY = 16;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef cnt_t [N_KEY-1:0] tab_t;

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

   // Half-period per note code; rest codes get 0 and are never looked up.
   function automatic tab_t build_tab();
      tab_t        tab;
      int unsigned f;
      for (int k = 0; k < int'(N_KEY); k++) begin
         case (k)
            1:       f = 262;
            2:       f = 294;
            3:       f = 330;
            4:       f = 349;
            5:       f = 392;
            6:       f = 440;
            7:       f = 494;
            8:       f = 523;
            9:       f = 587;
            10:      f = 659;
            11:      f = 698;
            12:      f = 784;
            13:      f = 880;
            14:      f = 988;
            default: f = 0;
         endcase
         tab[k] = (f == 0) ? '0 : CNT_W'(CLK_HZ / (2 * f));
      end
      return tab;
   endfunction

   localparam tab_t H_TAB = build_tab();

   state_t             state_q, state_d;
   logic               speaker_d, playing_d;
   logic [KEY_W-1:0]   cur_key_d;
   cnt_t               cnt_q, cnt_d;
   logic               valid_c;
   logic               terminal_c;

   assign valid_c    = key_on && (key != 4'd0) && (key != 4'd15);
   assign terminal_c = (cnt_q == H_TAB[cur_key] - CNT_W'(1));

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         speaker <= 1'b0;
         playing <= 1'b0;
         cur_key <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         speaker <= speaker_d;
         playing <= playing_d;
         cur_key <= cur_key_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      speaker_d = speaker;
      playing_d = playing;
      cur_key_d = cur_key;
      cnt_d     = cnt_q;

      case (state_q)
         IDLE: begin
            speaker_d = 1'b0;
            playing_d = 1'b0;
            cur_key_d = '0;
            cnt_d     = '0;
            if (valid_c) begin
               state_d   = PLAY;
               speaker_d = 1'b1;
               playing_d = 1'b1;
               cur_key_d = key;
            end
         end

         PLAY: begin
            if (terminal_c) begin
               // Half-period done: keep going with a freshly sampled key, or stop.
               if (valid_c) begin
                  speaker_d = ~speaker;
                  cur_key_d = key;
                  cnt_d     = '0;
               end else begin
                  state_d   = IDLE;
                  speaker_d = 1'b0;
                  playing_d = 1'b0;
                  cur_key_d = '0;
                  cnt_d     = '0;
               end
            end else if (!speaker && !valid_c) begin
               // Wave already low: stopping now cannot create a runt pulse.
               state_d   = IDLE;
               playing_d = 1'b0;
               cur_key_d = '0;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d   = IDLE;
            speaker_d = 1'b0;
            playing_d = 1'b0;
            cur_key_d = '0;
            cnt_d     = '0;
         end
      endcase
   end

endmodule
